// File: rtl/io_responder_pkg.sv
// -----------------------------------------------------------------------------
// io_responder_pkg
// Shared definitions for the processor I/O responder:
//   - FSM state encoding (legacy-style 2-bit constants)
//   - 16-entry active-low seven-segment table (bit 6..0 = segment g..a)
//   - default debounce length and bus widths
// -----------------------------------------------------------------------------
package io_responder_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int DATA_W                  = 32;
  localparam int SW_W                    = 18;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_HALTED       = 2'd3;

  // Active-low segments, g in bit 6 down to a in bit 0.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// -----------------------------------------------------------------------------
// io_if
// Processor <-> I/O responder handshake bundle.
//
// Handshake: the processor raises in_req for an input instruction and keeps
// it high until it sees in_ack. in_ack is a single-cycle pulse; in that cycle
// user_input is valid and stall is already low, so the instruction retires.
// stall = in_req & ~in_ack & ~halt (combinational). out_req is a one-cycle
// qualifier for out_data; it is only taken when no input request is present.
//
// Signals:
//   in_req     processor -> responder  input instruction executing
//   out_req    processor -> responder  output instruction executing
//   out_data   processor -> responder  value to display
//   user_input responder -> processor  accepted input word
//   in_ack     responder -> processor  input accepted (one-cycle pulse)
//   stall      responder -> processor  hold PC while input pending
// -----------------------------------------------------------------------------
interface io_if;
  import io_responder_pkg::*;

  logic              in_req;
  logic              out_req;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] user_input;
  logic              in_ack;
  logic              stall;

  modport master (
    output in_req, out_req, out_data,
    input  user_input, in_ack, stall
  );

  modport slave (
    input  in_req, out_req, out_data,
    output user_input, in_ack, stall
  );

endinterface

// File: rtl/io_responder_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Converts one hex nibble to an active-low seven-segment pattern.
// Ports:
//   i_nibble  in  4  value 0-F
//   o_seg     out 7  segments g..a in bits 6..0, 0 = lit
// -----------------------------------------------------------------------------
module hex_to_seg7
  import io_responder_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_lookup(i_nibble);

endmodule

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Services processor input/output instructions using a pushbutton, switches
// and eight seven-segment digits.
//   - insert is synchronised (2 flops) and debounced; a press is the debounced
//     level falling 1->0.
//   - An input instruction waits for a press, captures SW and pulses in_ack,
//     then waits for the button to be released before serving another input.
//   - An output instruction latches out_data for display.
//   - halt parks the FSM in HALTED until reset.
// Ports:
//   CLK          in   1   clock
//   reset        in   1   synchronous active-low reset
//   halt         in   1   processor halted
//   insert       in   1   raw pushbutton, active-low, asynchronous
//   SW           in  18   user switches
//   bus          io_if.slave  in_req/out_req/out_data/user_input/in_ack/stall
//   HEX0..HEX7   out  7   active-low digits, HEX0 = least significant nibble
//   o_dbg_state  out  2   current FSM state
// DEBOUNCE_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            halt,
  input  logic            insert,
  input  logic [SW_W-1:0] SW,
  io_if.slave             bus,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3,
  output logic [6:0]      HEX4,
  output logic [6:0]      HEX5,
  output logic [6:0]      HEX6,
  output logic [6:0]      HEX7,
  output logic [1:0]      o_dbg_state
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer
  // ---------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_done;
  logic             w_press;

  assign w_cnt_done = (r_cnt == CNT_LAST);

  // The press event is asserted on the same edge the debounced level falls,
  // so it is exactly one cycle wide without an extra edge-detect register.
  assign w_press = r_deb & ~r_sync2 & w_cnt_done;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= insert;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_deb) begin
        // Count consecutive disagreeing cycles; the last one flips the level.
        if (w_cnt_done) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Responder FSM
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_user_input;
  logic              r_in_ack;
  logic              w_accept;
  logic              w_latch_out;

  // Input beats output when both requests arrive together in IDLE.
  assign w_accept    = (r_state == ST_WAIT_PRESS) & ~halt & bus.in_req & w_press;
  assign w_latch_out = (r_state == ST_IDLE) & ~halt & ~bus.in_req & bus.out_req;

  always_comb begin
    w_next_state = r_state;
    if (halt) begin
      w_next_state = ST_HALTED;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_req) w_next_state = ST_WAIT_PRESS;
        end
        ST_WAIT_PRESS: begin
          if (!bus.in_req)  w_next_state = ST_IDLE;
          else if (w_press) w_next_state = ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          // A held button must be released before the next input can be served.
          if (r_deb) w_next_state = ST_IDLE;
        end
        ST_HALTED: begin
          w_next_state = ST_HALTED;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_disp       <= '0;
      r_user_input <= '0;
      r_in_ack     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_in_ack <= w_accept;
      if (w_accept) begin
        r_user_input <= {{(DATA_W - SW_W){1'b0}}, SW};
      end
      if (w_latch_out) begin
        r_disp <= bus.out_data;
      end
    end
  end

  assign bus.user_input = r_user_input;
  assign bus.in_ack     = r_in_ack;
  assign bus.stall      = bus.in_req & ~r_in_ack & ~halt;
  assign o_dbg_state    = r_state;

  // ---------------------------------------------------------------------------
  // Display: live switches while waiting for a press, latched value otherwise
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_disp;
  logic [6:0]        w_hex [8];

  assign w_disp = (r_state == ST_WAIT_PRESS) ? {{(DATA_W - SW_W){1'b0}}, SW} : r_disp;

  for (genvar g = 0; g < 8; g++) begin : g_hex
    hex_to_seg7 u_hex (
      .i_nibble (w_disp[g*4 +: 4]),
      .o_seg    (w_hex[g])
    );
  end

  assign HEX0 = w_hex[0];
  assign HEX1 = w_hex[1];
  assign HEX2 = w_hex[2];
  assign HEX3 = w_hex[3];
  assign HEX4 = w_hex[4];
  assign HEX5 = w_hex[5];
  assign HEX6 = w_hex[6];
  assign HEX7 = w_hex[7];

endmodule
